packet_read_arbiter: RTL and testbench
======================================

PACKET_READ_ARBITER -- requirements
Module: packet_read_arbiter

Interface
REQ-001 Parameter RAM_SIZE, default PACKET_BUFFER_SIZE: packet buffer depth in bytes; address width AW = clog2(RAM_SIZE).
REQ-002 clk  in  1  system clock; all state changes on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req  in  2  per-requester level request; held high until the matching done pulse.
REQ-005 req_start0, req_start1  in  AW  first byte address of each requester's packet.
REQ-006 req_end0, req_end1  in  AW  one past last byte; wraps modulo RAM_SIZE.
REQ-007 req_readclk  in  2  per-requester rate-limit strobe (downstream ready to take a byte).
REQ-008 gnt  out  2  one-hot grant; high from LOAD through the done cycle.
REQ-009 sfm_start, sfm_read_start[AW], sfm_read_end[AW], sfm_readclk  out  drive the shared memory streamer.
REQ-010 sfm_outclk, sfm_out[BYTE_LEN], sfm_done  in  byte strobe, byte, and last-byte pulse from the streamer.
REQ-011 outclk  out  2  per-requester byte strobe; out  out  BYTE_LEN  shared byte bus; done  out  2  per-requester completion pulse.

Function
REQ-012 FSM states: IDLE, LOAD, STREAM, RELEASE.
REQ-013 IDLE: when any req bit is high, the arbiter selects a winner, latches the winner's start/end addresses, registers gnt one-hot, and enters LOAD next cycle.
REQ-014 LOAD lasts exactly one cycle: sfm_start = 1, sfm_read_start and sfm_read_end = latched values, sfm_readclk = 0.
REQ-015 If the latched start equals the latched end (empty packet), the arbiter skips LOAD: IDLE -> RELEASE with done[g] pulsed for one cycle and no sfm_start.
REQ-016 STREAM: sfm_readclk = req_readclk[g] combinationally; req_readclk of the non-granted requester is ignored.
REQ-017 STREAM: outclk[g] = sfm_outclk and done[g] = sfm_done, both combinational; the other outclk and done bits are 0.
REQ-018 out = sfm_out at all times.
REQ-019 STREAM -> RELEASE on the cycle sfm_done = 1.
REQ-020 RELEASE lasts one cycle: gnt = 0, sfm_readclk = 0; then IDLE.
REQ-021 Minimum gap between consecutive grants: 1 idle cycle (RELEASE), then arbitration in IDLE.
REQ-022 Latency: req rising in IDLE at cycle N -> gnt and sfm_start at N+1 -> sfm_readclk enabled from N+2.
REQ-023 A sfm_outclk arriving outside STREAM shall be dropped: no outclk bit asserted.
REQ-024 Dropping req before done is a requester error; the arbiter completes the current transfer regardless.
REQ-025 Addresses are sampled only when leaving IDLE; later changes to req_start/req_end have no effect on the current transfer.

Reset
REQ-026 On rst the FSM shall enter IDLE with gnt = 0, sfm_start = 0, sfm_readclk = 0, outclk = 0, done = 0, latched addresses = 0, and round-robin pointer = 0.
REQ-027 rst mid-STREAM aborts the transfer with no done pulse; the streamer shares rst.
REQ-028 All outputs are driven low while rst is high.

Configuration
REQ-029 With PACKET_ARBITER_RR_EN defined: round-robin arbitration. The pointer names the last granted requester, and on simultaneous requests the other requester wins.
REQ-030 With PACKET_ARBITER_RR_EN undefined: fixed priority, requester 0 always wins, and no pointer register exists.

Verification
REQ-031 req=01, start0=10, end0=14, req_readclk[0] tied high -> gnt=01 for LOAD+STREAM; outclk[0] pulses 4 times with bytes at addresses 10..13; done[0] pulses once; gnt=00 in RELEASE.
REQ-032 req=11 held continuously, each packet 2 bytes -> with RR_EN, grants alternate 01,10,01; without RR_EN, grants stay 01 until req[0] drops.
REQ-033 start1=end1=5, req=10 -> done[1] pulses 1 cycle after the request; sfm_start never asserted.
REQ-034 start0=RAM_SIZE-2, end0=2 -> 4 bytes from addresses RAM_SIZE-2, RAM_SIZE-1, 0, 1, then done[0].
REQ-035 rst asserted on the 2nd byte of an 8-byte transfer -> gnt=00 next cycle, no done pulse, no further outclk; a new req=01 afterwards is granted normally.
REQ-036 In STREAM, toggle req_readclk[0] every 4 cycles and hold req_readclk[1] high -> sfm_readclk follows bit 0 only; outclk[1] stays 0.

Source files
------------

// File: rtl/packet_read_arbiter.sv
// Two-requester arbiter in front of the shared packet-buffer streamer.
// Define PACKET_ARBITER_RR_EN for round-robin; otherwise requester 0 has fixed priority.

`ifndef PACKET_BUFFER_SIZE
`define PACKET_BUFFER_SIZE 64
`endif

module packet_read_arbiter #(
    parameter int unsigned RAM_SIZE = `PACKET_BUFFER_SIZE,
    parameter int unsigned BYTE_LEN = 8,
    localparam int unsigned AW = $clog2(RAM_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [AW-1:0]       req_start0,
    input  logic [AW-1:0]       req_start1,
    input  logic [AW-1:0]       req_end0,
    input  logic [AW-1:0]       req_end1,
    input  logic [1:0]          req_readclk,
    output logic [1:0]          gnt,
    output logic                sfm_start,
    output logic [AW-1:0]       sfm_read_start,
    output logic [AW-1:0]       sfm_read_end,
    output logic                sfm_readclk,
    input  logic                sfm_outclk,
    input  logic [BYTE_LEN-1:0] sfm_out,
    input  logic                sfm_done,
    output logic [1:0]          outclk,
    output logic [BYTE_LEN-1:0] out,
    output logic [1:0]          done
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStream,
        StRelease
    } state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic [1:0]    r_gnt;
    logic          r_owner;
    logic          r_empty;
    logic [AW-1:0] r_start;
    logic [AW-1:0] r_end;

    logic          w_win;
    logic [AW-1:0] w_win_start;
    logic [AW-1:0] w_win_end;
    logic          w_win_empty;
    logic          w_accept;

`ifdef PACKET_ARBITER_RR_EN
    // Index of the most recently granted requester.
    logic r_ptr;

    always_comb begin
        w_win = 1'b0;
        if (req == 2'b11) begin
            w_win = ~r_ptr;
        end else begin
            w_win = req[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= w_win;
        end
    end
`else
    always_comb begin
        w_win = ~req[0];
    end
`endif

    assign w_win_start = w_win ? req_start1 : req_start0;
    assign w_win_end   = w_win ? req_end1   : req_end0;
    assign w_win_empty = (w_win_start == w_win_end);
    assign w_accept    = (r_state == StIdle) && (|req);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        sfm_start    = 1'b0;
        sfm_readclk  = 1'b0;
        outclk       = 2'b00;
        done         = 2'b00;
        unique case (r_state)
            StIdle: begin
                if (|req) begin
                    w_state_next = w_win_empty ? StRelease : StLoad;
                end
            end
            StLoad: begin
                sfm_start    = 1'b1;
                w_state_next = StStream;
            end
            StStream: begin
                sfm_readclk     = req_readclk[r_owner];
                outclk[r_owner] = sfm_outclk;
                done[r_owner]   = sfm_done;
                if (sfm_done) begin
                    w_state_next = StRelease;
                end
            end
            StRelease: begin
                // Empty packets complete here without ever touching the streamer.
                done[r_owner] = r_empty;
                w_state_next  = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
        if (rst) begin
            sfm_start   = 1'b0;
            sfm_readclk = 1'b0;
            outclk      = 2'b00;
            done        = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt   <= 2'b00;
            r_owner <= 1'b0;
            r_empty <= 1'b0;
            r_start <= '0;
            r_end   <= '0;
        end else if (w_accept) begin
            r_owner <= w_win;
            r_empty <= w_win_empty;
            r_start <= w_win_start;
            r_end   <= w_win_end;
            r_gnt   <= w_win_empty ? 2'b00 : (w_win ? 2'b10 : 2'b01);
        end else if ((r_state == StStream) && sfm_done) begin
            r_gnt <= 2'b00;
        end else if (r_state == StRelease) begin
            r_empty <= 1'b0;
        end
    end

    assign gnt            = rst ? 2'b00 : r_gnt;
    assign sfm_read_start = rst ? '0 : r_start;
    assign sfm_read_end   = rst ? '0 : r_end;
    assign out            = rst ? '0 : sfm_out;

endmodule

// File: tb/tb_packet_read_arbiter.sv
// Bench for packet_read_arbiter: behavioural streamer, per-requester byte scoreboards
// and an expected-grant queue.

module tb_packet_read_arbiter;

    localparam int unsigned RAM_SIZE = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned BL       = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req = 2'b00;
    logic [AW-1:0] req_start0 = '0;
    logic [AW-1:0] req_start1 = '0;
    logic [AW-1:0] req_end0 = '0;
    logic [AW-1:0] req_end1 = '0;
    logic [1:0]    req_readclk = 2'b11;
    logic [1:0]    gnt;
    logic          sfm_start;
    logic [AW-1:0] sfm_read_start;
    logic [AW-1:0] sfm_read_end;
    logic          sfm_readclk;
    logic          sfm_outclk = 1'b0;
    logic [BL-1:0] sfm_out = 8'hFF;
    logic          sfm_done = 1'b0;
    logic [1:0]    outclk;
    logic [BL-1:0] out;
    logic [1:0]    done;

    always #5 clk = ~clk;

    packet_read_arbiter #(
        .RAM_SIZE(RAM_SIZE),
        .BYTE_LEN(BL)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_start0    (req_start0),
        .req_start1    (req_start1),
        .req_end0      (req_end0),
        .req_end1      (req_end1),
        .req_readclk   (req_readclk),
        .gnt           (gnt),
        .sfm_start     (sfm_start),
        .sfm_read_start(sfm_read_start),
        .sfm_read_end  (sfm_read_end),
        .sfm_readclk   (sfm_readclk),
        .sfm_outclk    (sfm_outclk),
        .sfm_out       (sfm_out),
        .sfm_done      (sfm_done),
        .outclk        (outclk),
        .out           (out),
        .done          (done)
    );

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return 8'(a * 7 + 3);
    endfunction

    // Streamer: one byte per cycle the read strobe is high; data register is not reset.
    logic [AW-1:0] s_addr = '0;
    logic [AW-1:0] s_end = '0;
    logic          s_act = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            s_act      <= 1'b0;
            sfm_outclk <= 1'b0;
            sfm_done   <= 1'b0;
        end else begin
            sfm_outclk <= 1'b0;
            sfm_done   <= 1'b0;
            if (sfm_start) begin
                s_act  <= 1'b1;
                s_addr <= sfm_read_start;
                s_end  <= sfm_read_end;
            end else if (s_act && sfm_readclk) begin
                sfm_outclk <= 1'b1;
                sfm_out    <= mem_byte(s_addr);
                s_addr     <= AW'(s_addr + 1'b1);
                if (AW'(s_addr + 1'b1) == s_end) begin
                    sfm_done <= 1'b1;
                    s_act    <= 1'b0;
                end
            end
        end
    end

    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [1:0] gq[$];
    int         left[2] = '{0, 0};
    int         nbytes[2] = '{0, 0};
    int         ndone[2] = '{0, 0};
    int         nstart = 0;
    logic [1:0] prev_gnt = 2'b00;
    bit         toggle_en = 1'b0;
    int         tcnt = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_pkts(input int g, input logic [AW-1:0] st, input logic [AW-1:0] en,
                             input int n);
        logic [AW-1:0] a;
        for (int k = 0; k < n; k++) begin
            a = st;
            while (a != en) begin
                if (g == 0) q0.push_back(mem_byte(a));
                else q1.push_back(mem_byte(a));
                a = AW'(a + 1'b1);
            end
        end
    endtask

    // Advance to the next negedge, score DUT outputs, then model the requesters.
    task automatic step();
        logic [7:0] e;
        @(negedge clk);
        if (!rst) begin
            if (outclk != 2'b00) check_val("outclk_granted_only", 32'(outclk & ~gnt), 0);
            if (outclk[0]) begin
                nbytes[0]++;
                if (q0.size() == 0) check_val("byte0_unexpected", 1, 0);
                else begin
                    e = q0.pop_front();
                    check_val("byte0", 32'(out), 32'(e));
                end
            end
            if (outclk[1]) begin
                nbytes[1]++;
                if (q1.size() == 0) check_val("byte1_unexpected", 1, 0);
                else begin
                    e = q1.pop_front();
                    check_val("byte1", 32'(out), 32'(e));
                end
            end
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                if (gq.size() == 0) check_val("grant_unexpected", 32'(gnt), 0);
                else check_val("grant_order", 32'(gnt), 32'(gq.pop_front()));
            end
            if (gnt != 2'b00 && !sfm_start)
                check_val("readclk_follow", 32'(sfm_readclk), 32'(|(req_readclk & gnt)));
            if (sfm_start) nstart++;
            for (int g = 0; g < 2; g++) begin
                if (done[g]) begin
                    ndone[g]++;
                    if (left[g] > 0) left[g]--;
                    if (left[g] == 0) req[g] = 1'b0;
                end
            end
        end
        prev_gnt = gnt;
        if (toggle_en) begin
            tcnt++;
            if (tcnt % 4 == 0) req_readclk[0] = ~req_readclk[0];
        end
    endtask

    task automatic wait_clear(input int budget, input string tag);
        int n;
        n = 0;
        while ((left[0] != 0 || left[1] != 0) && n < budget) begin
            step();
            n++;
        end
        check_val(tag, 32'(left[0] != 0 || left[1] != 0), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  nb;
        int  nd;
        int  ns0;
        int  l0;
        int  l1;
        int  n;
        logic p;
        logic w;

        // Outputs forced low while reset is high, even with streamer data present.
        repeat (3) @(negedge clk);
        check_val("rst_outputs_low", 32'({gnt, sfm_start, sfm_readclk, outclk, done, out}), 0);
        rst = 1'b0;
        step();
        check_val("reset_gnt", 32'(gnt), 0);
        check_val("reset_ctrl", 32'({sfm_start, sfm_readclk, outclk, done}), 0);
        check_val("reset_addr", 32'({sfm_read_start, sfm_read_end}), 0);

        // Empty packet on requester 1: done one cycle after request, no streamer start.
        req_start1 = 5;
        req_end1   = 5;
        left[1]    = 1;
        ns0        = nstart;
        req        = 2'b10;
        step();
        check_val("empty_done", 32'(done), 32'(2'b10));
        check_val("empty_gnt", 32'(gnt), 0);
        step();
        check_val("empty_done_once", 32'(done), 0);
        check_val("empty_no_start", 32'(nstart - ns0), 0);

        // Both requesting, three 2-byte packets each.
        req_start0 = 0;
        req_end0   = 2;
        req_start1 = 4;
        req_end1   = 6;
        push_pkts(0, 0, 2, 3);
        push_pkts(1, 4, 6, 3);
        l0 = 3;
        l1 = 3;
        p  = 1'b1;
        while (l0 != 0 || l1 != 0) begin
`ifdef PACKET_ARBITER_RR_EN
            if (l0 != 0 && l1 != 0) w = ~p;
            else w = (l0 == 0);
`else
            w = (l0 == 0);
`endif
            gq.push_back(w ? 2'b10 : 2'b01);
            if (w) l1--;
            else l0--;
            p = w;
        end
        left[0] = 3;
        left[1] = 3;
        req     = 2'b11;
        wait_clear(200, "dual_timeout");
        step();
        step();
        check_val("dual_grants_consumed", 32'(gq.size()), 0);
        check_val("dual_bytes_consumed", 32'(q0.size() + q1.size()), 0);

        // Basic 4-byte packet with latency checks.
        req_start0 = 10;
        req_end0   = 14;
        push_pkts(0, 10, 14, 1);
        gq.push_back(2'b01);
        left[0] = 1;
        nb      = nbytes[0];
        nd      = ndone[0];
        req     = 2'b01;
        step();
        check_val("load_gnt", 32'(gnt), 32'(2'b01));
        check_val("load_start", 32'(sfm_start), 1);
        check_val("load_rd_start", 32'(sfm_read_start), 10);
        check_val("load_rd_end", 32'(sfm_read_end), 14);
        check_val("load_readclk", 32'(sfm_readclk), 0);
        step();
        check_val("stream_readclk", 32'(sfm_readclk), 1);
        check_val("stream_gnt", 32'(gnt), 32'(2'b01));
        wait_clear(50, "basic_timeout");
        step();
        check_val("release_gnt", 32'(gnt), 0);
        check_val("basic_nbytes", 32'(nbytes[0] - nb), 4);
        check_val("basic_ndone", 32'(ndone[0] - nd), 1);

        // Wrap-around packet.
        req_start0 = 5'(RAM_SIZE - 2);
        req_end0   = 2;
        push_pkts(0, 5'(RAM_SIZE - 2), 2, 1);
        gq.push_back(2'b01);
        left[0] = 1;
        nb      = nbytes[0];
        req     = 2'b01;
        wait_clear(50, "wrap_timeout");
        step();
        check_val("wrap_nbytes", 32'(nbytes[0] - nb), 4);

        // Rate limiting: only the granted requester's strobe reaches the streamer.
        req_start0  = 0;
        req_end0    = 8;
        push_pkts(0, 0, 8, 1);
        gq.push_back(2'b01);
        left[0]     = 1;
        tcnt        = 0;
        toggle_en   = 1'b1;
        req_readclk = 2'b10;
        req         = 2'b01;
        wait_clear(200, "toggle_timeout");
        toggle_en   = 1'b0;
        req_readclk = 2'b11;
        step();
        check_val("toggle_bytes_consumed", 32'(q0.size()), 0);

        // Reset on the second byte of an 8-byte transfer aborts it silently.
        push_pkts(0, 0, 8, 1);
        gq.push_back(2'b01);
        left[0] = 1;
        nb      = nbytes[0];
        nd      = ndone[0];
        req     = 2'b01;
        n       = 0;
        while (nbytes[0] != nb + 2 && n < 50) begin
            step();
            n++;
        end
        check_val("abort_reached_byte2", 32'(nbytes[0] - nb), 2);
        rst = 1'b1;
        #1;
        check_val("abort_rst_gated", 32'({outclk, done, gnt, sfm_readclk, out}), 0);
        q0.delete();
        gq.delete();
        left[0] = 0;
        req     = 2'b00;
        step();
        check_val("abort_gnt", 32'(gnt), 0);
        rst = 1'b0;
        nb  = nbytes[0];
        repeat (4) step();
        check_val("abort_no_done", 32'(ndone[0] - nd), 0);
        check_val("abort_no_bytes", 32'(nbytes[0] - nb), 0);

        req_start0 = 10;
        req_end0   = 12;
        push_pkts(0, 10, 12, 1);
        gq.push_back(2'b01);
        left[0] = 1;
        req     = 2'b01;
        wait_clear(50, "post_rst_timeout");
        step();
        check_val("post_rst_nbytes", 32'(nbytes[0] - nb), 2);

        step();
        check_val("final_queues", 32'(q0.size() + q1.size() + gq.size()), 0);
        check_val("final_nstart", 32'(nstart), 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
